axil_crossbar_sm_wr: RTL and testbench
======================================

AXIL_CROSSBAR_SM_WR -- requirements
Module: axil_crossbar_sm_wr

Interface
REQ-001 SHALL have parameter NUMBER_MASTER, default 4, number of masters behind the write crossbar.
REQ-002 SHALL have port aclk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port grant_wr  input  NUMBER_MASTER  write grant vector from the arbiter.
REQ-005 SHALL have port s_axil_awvalid  input  1  AW valid as driven to the slave by the forward mux.
REQ-006 SHALL have port s_axil_awready  input  1  AW ready from the slave.
REQ-007 SHALL have port s_axil_wvalid  input  1  W valid as driven to the slave by the forward mux.
REQ-008 SHALL have port s_axil_wready  input  1  W ready from the slave.
REQ-009 SHALL have port s_axil_bresp  input  2  write response from the slave.
REQ-010 SHALL have port s_axil_bvalid  input  1  B valid from the slave.
REQ-011 SHALL have port s_axil_bready  output  1  B ready to the slave; owned by this block.
REQ-012 SHALL have port m_axil_awready  output  NUMBER_MASTER  per-master AW ready.
REQ-013 SHALL have port m_axil_wready  output  NUMBER_MASTER  per-master W ready.
REQ-014 SHALL have port m_axil_bresp  output  2 x [NUMBER_MASTER] unpacked  per-master write response.
REQ-015 SHALL have port m_axil_bvalid  output  NUMBER_MASTER  per-master B valid.
REQ-016 SHALL have port m_axil_bready  input  NUMBER_MASTER  per-master B ready.
REQ-017 SHALL have port wr_done  output  1  one-cycle pulse on the master B handshake; tells the arbiter to release the grant.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR_DATA and RESP.
REQ-020 IDLE: when grant_wr != 0, SHALL latch sel = lowest set bit index (one-hot register) and enter ADDR_DATA next cycle; all master-side outputs 0 while in IDLE.
REQ-021 ADDR_DATA: SHALL drive m_axil_awready[sel] = s_axil_awready & ~aw_done and m_axil_wready[sel] = s_axil_wready & ~w_done, combinationally.
REQ-022 SHALL set aw_done on s_axil_awvalid & s_axil_awready and w_done on s_axil_wvalid & s_axil_wready, both while in ADDR_DATA; once set, the corresponding ready to the master SHALL remain 0.
REQ-023 SHALL enter RESP on the cycle after both flags are set; both handshakes in the same cycle SHALL also count, including the same cycle as the first ADDR_DATA cycle.
REQ-024 RESP: SHALL drive s_axil_bready = 1 while the one-entry response buffer is empty; on s_axil_bvalid & s_axil_bready SHALL capture s_axil_bresp and mark the buffer full.
REQ-025 With the buffer full, SHALL drive m_axil_bvalid[sel] = 1 and m_axil_bresp[sel] = the captured value, and SHALL drive s_axil_bready = 0; this gives 1-cycle slave-B to master-B latency.
REQ-026 The master B handshake is m_axil_bvalid[sel] & m_axil_bready[sel]; on it, wr_done SHALL be 1 in that cycle (combinational), and the block SHALL empty the buffer, clear sel and both flags, and return to IDLE next cycle.
REQ-027 Non-selected masters SHALL always see awready = 0, wready = 0, bvalid = 0 and bresp = 2'b00.
REQ-028 Changes to grant_wr outside IDLE SHALL be ignored; sel SHALL stay locked until return to IDLE.
REQ-029 A new grant present in the first IDLE cycle after wr_done SHALL be accepted normally, giving a minimum 1 IDLE cycle between transactions.
REQ-030 s_axil_bready SHALL be 0 in IDLE and ADDR_DATA; a B response arriving early SHALL wait.
REQ-031 SHALL hold m_axil_bvalid[sel] and m_axil_bresp[sel] stable until the master B handshake, regardless of m_axil_bready stalls.

Reset
REQ-032 While aresetn = 0 at a clock edge, SHALL set state = IDLE, sel = 0, aw_done = w_done = 0, buffer empty and captured bresp = 0.
REQ-033 During reset, all outputs SHALL be 0: s_axil_bready, m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bresp, wr_done and busy.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction with no wr_done pulse.

Verification
REQ-035 grant_wr = 4'b0100, slave ready immediately, AW and W together, bresp = 2'b00 -> m_axil_awready[2] and m_axil_wready[2] pulse once; RESP entered; m_axil_bvalid[2] asserted 1 cycle after slave B handshake; wr_done pulses once.
REQ-036 AW accepted 3 cycles before W, bresp = 2'b10 -> m_axil_awready[1] stays 0 after the AW handshake; m_axil_bresp[1] = 2'b10; other masters remain all-zero.
REQ-037 m_axil_bready[0] held low 5 cycles with bresp = 2'b11 -> m_axil_bvalid[0] and bresp stay stable; s_axil_bready = 0 throughout; wr_done only in the handshake cycle.
REQ-038 grant_wr = 4'b1010 in IDLE, then changed to 4'b0001 in ADDR_DATA -> sel = master 1 for the whole transaction.
REQ-039 aresetn driven low while in RESP with the buffer full -> next cycle all outputs 0, busy = 0, no wr_done; a fresh transaction completes normally afterwards.
REQ-040 s_axil_bvalid asserted during ADDR_DATA -> s_axil_bready = 0 until RESP; response then captured correctly.

Source files
------------

// File: rtl/axil_crossbar_sm_wr.sv
// Write-channel state machine for an AXI-Lite crossbar: routes slave AW/W readies and the
// buffered B response to the single master currently granted by the arbiter.
module axil_crossbar_sm_wr #(
  parameter int unsigned NUMBER_MASTER = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] grant_wr,
  input  logic                     s_axil_awvalid,
  input  logic                     s_axil_awready,
  input  logic                     s_axil_wvalid,
  input  logic                     s_axil_wready,
  input  logic [1:0]               s_axil_bresp,
  input  logic                     s_axil_bvalid,
  output logic                     s_axil_bready,
  output logic [NUMBER_MASTER-1:0] m_axil_awready,
  output logic [NUMBER_MASTER-1:0] m_axil_wready,
  output logic [1:0]               m_axil_bresp [NUMBER_MASTER],
  output logic [NUMBER_MASTER-1:0] m_axil_bvalid,
  input  logic [NUMBER_MASTER-1:0] m_axil_bready,
  output logic                     wr_done,
  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StAddrData, StResp} state_e;

  state_e                   state_q, state_d;
  logic [NUMBER_MASTER-1:0] sel_q, sel_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic                     buf_full_q, buf_full_d;
  logic [1:0]               bresp_q, bresp_d;

  logic [NUMBER_MASTER-1:0] grant_low;
  logic                     grant_found;
  logic                     addr_act, resp_act;
  logic                     aw_hs, w_hs, s_b_hs, m_b_hs;

  // Lowest-index grant wins if the arbiter ever presents more than one bit.
  always_comb begin
    grant_low   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < int'(NUMBER_MASTER); i++) begin
      if (grant_wr[i] && !grant_found) begin
        grant_low[i] = 1'b1;
        grant_found  = 1'b1;
      end
    end
  end

  // Outputs are gated by aresetn so they read zero for the whole reset window,
  // not only after the first reset edge.
  assign addr_act = aresetn && (state_q == StAddrData);
  assign resp_act = aresetn && (state_q == StResp);

  always_comb begin
    m_axil_awready = '0;
    m_axil_wready  = '0;
    m_axil_bvalid  = '0;
    for (int i = 0; i < int'(NUMBER_MASTER); i++) begin
      m_axil_awready[i] = addr_act & sel_q[i] & s_axil_awready & ~aw_done_q;
      m_axil_wready[i]  = addr_act & sel_q[i] & s_axil_wready & ~w_done_q;
      m_axil_bvalid[i]  = resp_act & sel_q[i] & buf_full_q;
      m_axil_bresp[i]   = (resp_act && sel_q[i] && buf_full_q) ? bresp_q : 2'b00;
    end
  end

  assign s_axil_bready = resp_act & ~buf_full_q;
  assign aw_hs         = addr_act & s_axil_awvalid & s_axil_awready;
  assign w_hs          = addr_act & s_axil_wvalid & s_axil_wready;
  assign s_b_hs        = s_axil_bvalid & s_axil_bready;
  assign m_b_hs        = |(m_axil_bvalid & m_axil_bready);
  assign wr_done       = m_b_hs;
  assign busy          = aresetn && (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    buf_full_d = buf_full_q;
    bresp_d    = bresp_q;
    unique case (state_q)
      StIdle: begin
        if (|grant_wr) begin
          sel_d   = grant_low;
          state_d = StAddrData;
        end
      end
      StAddrData: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // Same-cycle handshakes on both channels count, even on the first cycle here.
        if (aw_done_d && w_done_d) state_d = StResp;
      end
      StResp: begin
        if (s_b_hs) begin
          buf_full_d = 1'b1;
          bresp_d    = s_axil_bresp;
        end
        if (m_b_hs) begin
          buf_full_d = 1'b0;
          sel_d      = '0;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      buf_full_q <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      buf_full_q <= buf_full_d;
      bresp_q    <= bresp_d;
    end
  end

endmodule

// File: tb/tb_axil_crossbar_sm_wr.sv
// Directed bench for axil_crossbar_sm_wr: walks through each scenario cycle by cycle and
// compares every output against hand-computed values.
module tb_axil_crossbar_sm_wr;

  localparam int unsigned N = 4;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [N-1:0] grant_wr;
  logic         s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [1:0]   s_axil_bresp;
  logic         s_axil_bvalid, s_axil_bready;
  logic [N-1:0] m_axil_awready, m_axil_wready, m_axil_bvalid, m_axil_bready;
  logic [1:0]   m_axil_bresp [N];
  logic         wr_done, busy;
  logic [7:0]   bresp_flat;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axil_crossbar_sm_wr #(.NUMBER_MASTER(N)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .grant_wr       (grant_wr),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .m_axil_awready (m_axil_awready),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .wr_done        (wr_done),
    .busy           (busy)
  );

  assign bresp_flat = {m_axil_bresp[3], m_axil_bresp[2], m_axil_bresp[1], m_axil_bresp[0]};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] awr, input logic [3:0] wr,
                            input logic [3:0] bv, input logic [7:0] br, input logic sbr,
                            input logic done, input logic bsy);
    #1;
    chk({tag, "_awready"}, 16'(m_axil_awready), 16'(awr));
    chk({tag, "_wready"},  16'(m_axil_wready),  16'(wr));
    chk({tag, "_bvalid"},  16'(m_axil_bvalid),  16'(bv));
    chk({tag, "_bresp"},   16'(bresp_flat),     16'(br));
    chk({tag, "_s_bready"}, 16'(s_axil_bready), 16'(sbr));
    chk({tag, "_wr_done"}, 16'(wr_done),        16'(done));
    chk({tag, "_busy"},    16'(busy),           16'(bsy));
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic slave_aw(input logic v, input logic r);
    s_axil_awvalid = v;
    s_axil_awready = r;
  endtask

  task automatic slave_w(input logic v, input logic r);
    s_axil_wvalid = v;
    s_axil_wready = r;
  endtask

  initial begin
    aresetn = 1'b0;
    grant_wr = '0;
    slave_aw(1'b0, 1'b0);
    slave_w(1'b0, 1'b0);
    s_axil_bresp = 2'b00;
    s_axil_bvalid = 1'b0;
    m_axil_bready = '0;

    // Reset: everything low, even with a grant pending.
    tick();
    grant_wr = 4'b0100;
    expect_out("rst0", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("rst1", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Master 2, AW and W together, bresp OKAY.
    aresetn = 1'b1;
    expect_out("s1_idle", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    slave_aw(1'b1, 1'b1);
    slave_w(1'b1, 1'b1);
    expect_out("s1_addr", 4'b0100, 4'b0100, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    slave_aw(1'b0, 1'b1);
    slave_w(1'b0, 1'b1);
    grant_wr = '0;
    s_axil_bvalid = 1'b1;
    s_axil_bresp = 2'b00;
    expect_out("s1_resp", 4'h0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    s_axil_bvalid = 1'b0;
    m_axil_bready = 4'b0100;
    expect_out("s1_bhs", 4'h0, 4'h0, 4'b0100, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    m_axil_bready = '0;
    // Back-to-back grant in the first idle cycle, master 1.
    grant_wr = 4'b0010;
    expect_out("s2_idle", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Master 1: AW three cycles ahead of W, early slave B must wait, bresp SLVERR.
    tick();
    grant_wr = '0;
    slave_aw(1'b1, 1'b1);
    slave_w(1'b0, 1'b1);
    expect_out("s2_aw", 4'b0010, 4'b0010, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    slave_aw(1'b0, 1'b1);
    s_axil_bvalid = 1'b1;
    s_axil_bresp = 2'b10;
    expect_out("s2_wait1", 4'h0, 4'b0010, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("s2_wait2", 4'h0, 4'b0010, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    slave_w(1'b1, 1'b1);
    expect_out("s2_w", 4'h0, 4'b0010, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    slave_w(1'b0, 1'b1);
    expect_out("s2_resp", 4'h0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    s_axil_bvalid = 1'b0;
    expect_out("s2_full", 4'h0, 4'h0, 4'b0010, 8'b00_00_10_00, 1'b0, 1'b0, 1'b1);
    m_axil_bready = 4'b0010;
    expect_out("s2_bhs", 4'h0, 4'h0, 4'b0010, 8'b00_00_10_00, 1'b0, 1'b1, 1'b1);
    tick();
    m_axil_bready = '0;
    expect_out("s2_idle", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Master 0: bready stalled five cycles, bresp DECERR held; late slave B ignored.
    grant_wr = 4'b0001;
    tick();
    grant_wr = '0;
    slave_aw(1'b1, 1'b1);
    slave_w(1'b1, 1'b1);
    expect_out("s3_addr", 4'b0001, 4'b0001, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    slave_aw(1'b0, 1'b0);
    slave_w(1'b0, 1'b0);
    s_axil_bvalid = 1'b1;
    s_axil_bresp = 2'b11;
    tick();
    s_axil_bresp = 2'b01;
    for (int c = 0; c < 5; c++) begin
      expect_out($sformatf("s3_stall%0d", c), 4'h0, 4'h0, 4'b0001, 8'b00_00_00_11,
                 1'b0, 1'b0, 1'b1);
      tick();
    end
    s_axil_bvalid = 1'b0;
    m_axil_bready = 4'b0001;
    expect_out("s3_bhs", 4'h0, 4'h0, 4'b0001, 8'b00_00_00_11, 1'b0, 1'b1, 1'b1);
    tick();
    m_axil_bready = '0;
    expect_out("s3_idle", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Grant 1010 picks master 1; a later grant change is ignored.
    grant_wr = 4'b1010;
    tick();
    grant_wr = 4'b0001;
    slave_aw(1'b1, 1'b1);
    expect_out("s4_aw", 4'b0010, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    slave_aw(1'b0, 1'b0);
    slave_w(1'b1, 1'b1);
    expect_out("s4_w", 4'h0, 4'b0010, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    slave_w(1'b0, 1'b0);
    s_axil_bvalid = 1'b1;
    s_axil_bresp = 2'b01;
    tick();
    s_axil_bvalid = 1'b0;
    m_axil_bready = 4'b0001;
    expect_out("s4_wrongrdy", 4'h0, 4'h0, 4'b0010, 8'b00_00_01_00, 1'b0, 1'b0, 1'b1);
    grant_wr = '0;
    m_axil_bready = 4'b0010;
    expect_out("s4_bhs", 4'h0, 4'h0, 4'b0010, 8'b00_00_01_00, 1'b0, 1'b1, 1'b1);
    tick();
    m_axil_bready = '0;
    expect_out("s4_idle", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Master 3: reset while the response buffer is full abandons the transaction.
    grant_wr = 4'b1000;
    tick();
    grant_wr = '0;
    slave_aw(1'b1, 1'b1);
    slave_w(1'b1, 1'b1);
    tick();
    slave_aw(1'b0, 1'b0);
    slave_w(1'b0, 1'b0);
    s_axil_bvalid = 1'b1;
    s_axil_bresp = 2'b10;
    tick();
    s_axil_bvalid = 1'b0;
    expect_out("s5_full", 4'h0, 4'h0, 4'b1000, 8'b10_00_00_00, 1'b0, 1'b0, 1'b1);
    aresetn = 1'b0;
    m_axil_bready = 4'b1000;
    expect_out("s5_rst", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    aresetn = 1'b1;
    m_axil_bready = '0;
    expect_out("s5_after", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fresh transaction on master 0 after the reset.
    grant_wr = 4'b0001;
    tick();
    grant_wr = '0;
    slave_aw(1'b1, 1'b1);
    slave_w(1'b1, 1'b1);
    expect_out("s6_addr", 4'b0001, 4'b0001, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    slave_aw(1'b0, 1'b0);
    slave_w(1'b0, 1'b0);
    s_axil_bvalid = 1'b1;
    s_axil_bresp = 2'b00;
    expect_out("s6_resp", 4'h0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    s_axil_bvalid = 1'b0;
    m_axil_bready = 4'b1111;
    expect_out("s6_bhs", 4'h0, 4'h0, 4'b0001, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    m_axil_bready = '0;
    expect_out("s6_idle", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
